// File: rtl/delay_line_pkg.sv
// Operating-mode encoding shared by the tapped delay line and the blocks that drive it.
package delay_line_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_SHIFT  = 2'b01,
      MODE_ROTATE = 2'b10,
      MODE_LOAD   = 2'b11
   } mode_e;

endpackage

// File: rtl/tapped_delay_line.sv
// DEPTH-stage shift/rotate/load word register with fill tracking and a registered,
// range-checked tap read that always samples the pre-edge stage contents.
module tapped_delay_line
   import delay_line_pkg::*;
#(
   parameter  int DEPTH = 21,
   parameter  int WIDTH = 8,
   localparam int TAP_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] word_in,
   input  logic [TAP_W-1:0] tap_sel,
   output logic [WIDTH-1:0] word_out,
   output logic [WIDTH-1:0] tap_out,
   output logic             tap_err,
   output logic [CNT_W-1:0] fill_count,
   output logic             full,
   output logic             empty,
   output logic             out_valid
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] tap_q, tap_d;
   logic             tap_err_q, tap_err_d;
   logic             tap_oob;

   assign tap_oob = (32'(tap_sel) >= DEPTH);

   always_comb begin
      stage_d = stage_q;
      cnt_d   = cnt_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
         cnt_d = '0;
      end else begin
         case (mode_e'(mode))
            MODE_SHIFT: begin
               for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
               stage_d[0] = word_in;
               // Saturate at DEPTH: the oldest word is simply dropped once full.
               if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
            end
            MODE_ROTATE: begin
               for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
               stage_d[0] = stage_q[DEPTH-1];
            end
            MODE_LOAD: begin
               for (int i = 0; i < DEPTH; i++) stage_d[i] = word_in;
               cnt_d = CNT_FULL;
            end
            default: ;
         endcase
      end
   end

   // The tap reads stage_q, not stage_d, so its latency is one cycle whatever the mode.
   always_comb begin
      tap_d     = '0;
      tap_err_d = 1'b1;
      if (!tap_oob) begin
         tap_d     = stage_q[tap_sel];
         tap_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q   <= '{default: '0};
         cnt_q     <= '0;
         tap_q     <= '0;
         tap_err_q <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         cnt_q     <= cnt_d;
         tap_q     <= tap_d;
         tap_err_q <= tap_err_d;
      end
   end

   assign word_out   = stage_q[DEPTH-1];
   assign tap_out    = tap_q;
   assign tap_err    = tap_err_q;
   assign fill_count = cnt_q;
   assign full       = (cnt_q == CNT_FULL);
   assign empty      = (cnt_q == '0);
   assign out_valid  = full;

endmodule

// File: tb/tb_tapped_delay_line.sv
// Directed bench: a DEPTH=4 instance checked against a reference model through a scoreboard,
// and a DEPTH=5 instance for out-of-range tap selects.
module tb_tapped_delay_line;
   import delay_line_pkg::*;

   typedef struct {
      logic [7:0] wo;
      logic [7:0] to;
      logic       te;
      logic [2:0] fc;
      logic       fu;
      logic       em;
      logic       ov;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, flush4, te4, full4, empty4, ov4;
   logic [1:0] mode4, ts4;
   logic [7:0] win4, wo4, to4;
   logic [2:0] fc4;

   logic       rst5, flush5, te5, full5, empty5, ov5;
   logic [1:0] mode5;
   logic [2:0] ts5, fc5;
   logic [7:0] win5, wo5, to5;

   tapped_delay_line #(.DEPTH(4), .WIDTH(8)) u_d4 (
      .clk(clk), .reset(rst4), .flush(flush4), .mode(mode4), .word_in(win4),
      .tap_sel(ts4), .word_out(wo4), .tap_out(to4), .tap_err(te4),
      .fill_count(fc4), .full(full4), .empty(empty4), .out_valid(ov4)
   );

   tapped_delay_line #(.DEPTH(5), .WIDTH(8)) u_d5 (
      .clk(clk), .reset(rst5), .flush(flush5), .mode(mode5), .word_in(win5),
      .tap_sel(ts5), .word_out(wo5), .tap_out(to5), .tap_err(te5),
      .fill_count(fc5), .full(full5), .empty(empty5), .out_valid(ov5)
   );

   logic [7:0] m_stage [4];
   logic [2:0] m_cnt;
   logic [7:0] m_tap;
   logic       m_err;

   exp_t       q4[$];
   logic [8:0] q5[$];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check4();
      exp_t e;
      if (q4.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL q4_underflow observed=0 expected=1");
      end else begin
         e = q4.pop_front();
         chk("word_out",   32'(wo4),    32'(e.wo));
         chk("tap_out",    32'(to4),    32'(e.to));
         chk("tap_err",    32'(te4),    32'(e.te));
         chk("fill_count", 32'(fc4),    32'(e.fc));
         chk("full",       32'(full4),  32'(e.fu));
         chk("empty",      32'(empty4), 32'(e.em));
         chk("out_valid",  32'(ov4),    32'(e.ov));
      end
   endtask

   task automatic step4(input logic rst, input logic fl, input logic [1:0] md,
                        input logic [7:0] w, input logic [1:0] ts);
      logic [7:0] old [4];
      exp_t e;
      old = m_stage;
      if (rst) begin
         foreach (m_stage[i]) m_stage[i] = 8'h00;
         m_cnt = 3'd0;
         m_tap = 8'h00;
         m_err = 1'b0;
      end else begin
         m_tap = old[ts];
         m_err = 1'b0;
         if (fl) begin
            foreach (m_stage[i]) m_stage[i] = 8'h00;
            m_cnt = 3'd0;
         end else begin
            case (md)
               2'b01: begin
                  for (int i = 3; i > 0; i--) m_stage[i] = old[i-1];
                  m_stage[0] = w;
                  if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
               end
               2'b10: begin
                  for (int i = 3; i > 0; i--) m_stage[i] = old[i-1];
                  m_stage[0] = old[3];
               end
               2'b11: begin
                  foreach (m_stage[i]) m_stage[i] = w;
                  m_cnt = 3'd4;
               end
               default: ;
            endcase
         end
      end
      e.wo = m_stage[3];
      e.to = m_tap;
      e.te = m_err;
      e.fc = m_cnt;
      e.fu = (m_cnt == 3'd4);
      e.em = (m_cnt == 3'd0);
      e.ov = e.fu;
      q4.push_back(e);
      rst4 = rst; flush4 = fl; mode4 = md; win4 = w; ts4 = ts;
      @(posedge clk);
      #1;
      check4();
   endtask

   task automatic step5(input logic rst, input logic [1:0] md, input logic [7:0] w,
                        input logic [2:0] ts, input logic [7:0] exp_to, input logic exp_te);
      logic [8:0] got;
      q5.push_back({exp_te, exp_to});
      rst5 = rst; mode5 = md; win5 = w; ts5 = ts;
      @(posedge clk);
      #1;
      if (q5.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL q5_underflow observed=0 expected=1");
      end else begin
         got = q5.pop_front();
         chk("d5_tap_out", 32'(to5), 32'(got[7:0]));
         chk("d5_tap_err", 32'(te5), 32'(got[8]));
      end
   endtask

   initial begin
      rst4 = 1'b0; flush4 = 1'b0; mode4 = 2'b00; win4 = 8'h00; ts4 = 2'd0;
      rst5 = 1'b0; flush5 = 1'b0; mode5 = 2'b00; win5 = 8'h00; ts5 = 3'd0;
      foreach (m_stage[i]) m_stage[i] = 8'h00;
      m_cnt = 3'd0; m_tap = 8'h00; m_err = 1'b0;

      // Reset state
      step4(1'b1, 1'b0, MODE_HOLD, 8'h00, 2'd0);
      chk("rst_empty", 32'(empty4), 32'd1);
      chk("rst_word_out", 32'(wo4), 32'h00);

      // Fill
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h11, 2'd0); chk("fill1", 32'(fc4), 32'd1);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h22, 2'd0); chk("fill2", 32'(fc4), 32'd2);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h33, 2'd0); chk("fill3", 32'(fc4), 32'd3);
      chk("fill3_not_valid", 32'(ov4), 32'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h44, 2'd0); chk("fill4", 32'(fc4), 32'd4);
      chk("fill4_valid", 32'(ov4), 32'd1);
      chk("fill4_word_out", 32'(wo4), 32'h11);

      // Saturation
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h55, 2'd0);
      chk("sat_word_out", 32'(wo4), 32'h22);
      chk("sat_fill", 32'(fc4), 32'd4);
      chk("sat_full", 32'(full4), 32'd1);
      step4(1'b0, 1'b0, MODE_HOLD, 8'h99, 2'd3);
      chk("hold_tap3", 32'(to4), 32'h22);

      // Flush, refill to {44,33,22,11}, then rotate a full turn
      step4(1'b0, 1'b1, MODE_HOLD, 8'h00, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h11, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h22, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h33, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h44, 2'd0);
      step4(1'b0, 1'b0, MODE_ROTATE, 8'hEE, 2'd0); chk("rot1_tap", 32'(to4), 32'h44);
      step4(1'b0, 1'b0, MODE_ROTATE, 8'hEE, 2'd0); chk("rot2_tap", 32'(to4), 32'h11);
      step4(1'b0, 1'b0, MODE_ROTATE, 8'hEE, 2'd0); chk("rot3_tap", 32'(to4), 32'h22);
      step4(1'b0, 1'b0, MODE_ROTATE, 8'hEE, 2'd0); chk("rot4_tap", 32'(to4), 32'h33);
      chk("rot4_word_out", 32'(wo4), 32'h11);
      chk("rot4_fill", 32'(fc4), 32'd4);
      step4(1'b0, 1'b0, MODE_HOLD, 8'h00, 2'd0); chk("rot5_tap", 32'(to4), 32'h44);

      // LOAD then flush overriding SHIFT
      step4(1'b0, 1'b0, MODE_LOAD, 8'hA5, 2'd0);
      chk("load_fill", 32'(fc4), 32'd4);
      chk("load_word_out", 32'(wo4), 32'hA5);
      step4(1'b0, 1'b1, MODE_SHIFT, 8'h5A, 2'd2);
      chk("flush_tap_pre", 32'(to4), 32'hA5);
      chk("flush_fill", 32'(fc4), 32'd0);
      chk("flush_empty", 32'(empty4), 32'd1);
      chk("flush_word_out", 32'(wo4), 32'h00);
      step4(1'b0, 1'b0, MODE_HOLD, 8'h00, 2'd1);
      chk("flush_tap_post", 32'(to4), 32'h00);

      // Reset mid-operation wins over LOAD
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h01, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h02, 2'd0);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h03, 2'd0);
      step4(1'b1, 1'b0, MODE_LOAD, 8'hFF, 2'd0);
      chk("midrst_fill", 32'(fc4), 32'd0);
      chk("midrst_word_out", 32'(wo4), 32'h00);
      chk("midrst_tap", 32'(to4), 32'h00);
      chk("midrst_empty", 32'(empty4), 32'd1);
      step4(1'b0, 1'b0, MODE_SHIFT, 8'h77, 2'd0);
      chk("post_rst_fill", 32'(fc4), 32'd1);
      step4(1'b0, 1'b0, MODE_ROTATE, 8'h00, 2'd0);
      chk("rot_partial_fill", 32'(fc4), 32'd1);
      step4(1'b0, 1'b0, MODE_HOLD, 8'h00, 2'd1);
      chk("rot_partial_tap1", 32'(to4), 32'h77);

      // Out-of-range taps on a non-power-of-two depth
      step5(1'b1, MODE_HOLD, 8'h00, 3'd0, 8'h00, 1'b0);
      chk("d5_rst_empty", 32'(empty5), 32'd1);
      chk("d5_rst_valid", 32'(ov5), 32'd0);
      step5(1'b0, MODE_SHIFT, 8'h10, 3'd0, 8'h00, 1'b0);
      step5(1'b0, MODE_SHIFT, 8'h20, 3'd0, 8'h10, 1'b0);
      step5(1'b0, MODE_SHIFT, 8'h30, 3'd0, 8'h20, 1'b0);
      step5(1'b0, MODE_SHIFT, 8'h40, 3'd0, 8'h30, 1'b0);
      step5(1'b0, MODE_SHIFT, 8'h50, 3'd0, 8'h40, 1'b0);
      step5(1'b0, MODE_HOLD, 8'h00, 3'd6, 8'h00, 1'b1);
      step5(1'b0, MODE_HOLD, 8'h00, 3'd2, 8'h30, 1'b0);
      step5(1'b0, MODE_HOLD, 8'h00, 3'd5, 8'h00, 1'b1);
      step5(1'b0, MODE_HOLD, 8'h00, 3'd4, 8'h10, 1'b0);
      chk("d5_word_out", 32'(wo5), 32'h10);
      chk("d5_full", 32'(full5), 32'd1);
      chk("d5_fill", 32'(fc5), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
